// File: rtl/ifetch_pkg.sv
// Shared types and default sizes for the instruction fetch unit.
//   fetch_state_t : RUN (normal fetching) / DRAIN (discarding stale responses)
//   DEF_*         : default WIDTH / ILEN / DEPTH for the unit and its interface
package ifetch_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_ILEN  = 32;
  localparam int DEF_DEPTH = 2;

endpackage

// File: rtl/ifetch_if.sv
// Handshake bundle between the fetch unit, instruction memory and decode.
//   pc_in/pc_valid/pc_ready            : next-PC request (word index)
//   flush                              : discard queued and in-flight fetches
//   imem_req/imem_addr                 : memory read request
//   imem_rvalid/imem_rdata             : in-order memory read response
//   instr_valid/instr_ready/
//   instr_data/instr_pc                : decode-side handshake
// master = fetch unit side, slave = environment side.
interface ifetch_if
  import ifetch_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ILEN  = DEF_ILEN
);
  logic [WIDTH-1:0] pc_in;
  logic             pc_valid;
  logic             pc_ready;
  logic             flush;
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_rvalid;
  logic [ILEN-1:0]  imem_rdata;
  logic             instr_valid;
  logic             instr_ready;
  logic [ILEN-1:0]  instr_data;
  logic [WIDTH-1:0] instr_pc;

  modport master (
    input  pc_in, pc_valid, flush, imem_rvalid, imem_rdata, instr_ready,
    output pc_ready, imem_req, imem_addr, instr_valid, instr_data, instr_pc
  );

  modport slave (
    output pc_in, pc_valid, flush, imem_rvalid, imem_rdata, instr_ready,
    input  pc_ready, imem_req, imem_addr, instr_valid, instr_data, instr_pc
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: accepts PCs, issues memory reads with no added
// latency, queues responses in a DEPTH-slot in-order queue and hands them to
// decode. A flush empties the queue; responses still in flight at that point
// are counted and discarded in DRAIN before new PCs are accepted.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : ifetch_if.master (PC, memory and decode handshakes)
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ILEN  = DEF_ILEN,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic     clk,
  input  logic     rst,
  ifetch_if.master bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  typedef logic [PW-1:0] ptr_t;
  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

  // Queue storage
  logic [WIDTH-1:0] slot_pc   [DEPTH];
  logic [ILEN-1:0]  slot_data [DEPTH];
  logic [DEPTH-1:0] slot_filled;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  ptr_t alloc_q, fill_q, rd_q;
  ptr_t drop_q, drop_d;
  fetch_state_t state_q, state_d;

  ptr_t          count, pending;
  logic [IW-1:0] alloc_idx, fill_idx, rd_idx;
  logic          pop, accept, rsp, fill_en;

  assign count     = alloc_q - rd_q;
  assign pending   = alloc_q - fill_q;
  assign alloc_idx = alloc_q[IW-1:0];
  assign fill_idx  = fill_q[IW-1:0];
  assign rd_idx    = rd_q[IW-1:0];

  assign bus.instr_valid = !rst && !bus.flush && slot_filled[rd_idx] && (count != '0);
  assign pop             = bus.instr_valid && bus.instr_ready;
  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign bus.pc_ready    = (state_q == RUN) && !bus.flush && !rst &&
                           ((count < DEPTH_P) || pop);
  assign accept          = bus.pc_valid && bus.pc_ready;

  assign bus.imem_req    = accept;
  assign bus.imem_addr   = rst ? '0 : bus.pc_in;
  assign bus.instr_data  = rst ? '0 : slot_data[rd_idx];
  assign bus.instr_pc    = rst ? '0 : slot_pc[rd_idx];

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp     = bus.imem_rvalid && (pending != '0);
  assign fill_en = (state_q == RUN) && !bus.flush && rsp;

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    case (state_q)
      RUN: begin
        if (bus.flush) begin
          // A response landing in the flush cycle is already discarded.
          drop_d  = pending - ptr_t'(rsp);
          state_d = (drop_d != '0) ? DRAIN : RUN;
        end
      end
      DRAIN: begin
        // Flush here does not re-arm the counter: the queue is already empty
        // and nothing new was issued, so the outstanding count stays valid.
        if (bus.imem_rvalid && (drop_q != '0)) begin
          drop_d = drop_q - ptr_t'(1);
          if (drop_q == ptr_t'(1)) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      drop_q      <= '0;
      alloc_q     <= '0;
      fill_q      <= '0;
      rd_q        <= '0;
      slot_filled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_pc[i]   <= '0;
        slot_data[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      if (bus.flush) begin
        fill_q      <= alloc_q;
        rd_q        <= alloc_q;
        slot_filled <= '0;
      end else begin
        // Fill, pop and accept never target the same slot except accept
        // reusing the slot a pop frees this cycle; accept is written last.
        if (fill_en) begin
          slot_data[fill_idx]   <= bus.imem_rdata;
          slot_filled[fill_idx] <= 1'b1;
          fill_q                <= fill_q + ptr_t'(1);
        end
        if (pop) begin
          slot_pc[rd_idx]     <= '0;
          slot_data[rd_idx]   <= '0;
          slot_filled[rd_idx] <= 1'b0;
          rd_q                <= rd_q + ptr_t'(1);
        end
        if (accept) begin
          slot_pc[alloc_idx]     <= bus.pc_in;
          slot_filled[alloc_idx] <= 1'b0;
          alloc_q                <= alloc_q + ptr_t'(1);
        end
      end
    end
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving PC/address width in bits.
REQ-002 The module SHALL have parameter ILEN, default 32, giving instruction width in bits.
REQ-003 The module SHALL have parameter DEPTH, default 2, giving fetch-queue slots (power of two, >=2).
REQ-004 The module SHALL have port clk, input, 1 bit: clock, all state updates on the rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The module SHALL have ports pc_in (input, WIDTH): word-index PC; pc_valid (input, 1): PC valid; pc_ready (output, 1): PC accepted this cycle.
REQ-007 The module SHALL have port flush, input, 1 bit: discard all queued and in-flight fetches.
REQ-008 The module SHALL have ports imem_req (output, 1) and imem_addr (output, WIDTH): memory read request; imem_rvalid (input, 1) and imem_rdata (input, ILEN): in-order read response.
REQ-009 The module SHALL have ports instr_valid (output, 1), instr_ready (input, 1), instr_data (output, ILEN) and instr_pc (output, WIDTH): decode-side handshake.

Function
REQ-010 Queue: DEPTH slots of {pc, data, filled}; pointers alloc, fill, rd, each log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; count = alloc - rd; pending = alloc - fill.
REQ-011 FSM states: RUN, DRAIN; reset state RUN.
REQ-012 pop = instr_valid && instr_ready; pc_ready = (state==RUN) && !flush && !rst && (count<DEPTH || pop).
REQ-013 accept = pc_valid && pc_ready; imem_req = accept; imem_addr = pc_in; both combinational, zero added latency.
REQ-014 On accept, slot[alloc].pc <= pc_in, slot[alloc].filled <= 0, alloc increments.
REQ-015 In RUN, imem_rvalid with pending>0: slot[fill].data <= imem_rdata, filled <= 1, fill increments.
REQ-016 instr_valid = slot[rd].filled && count>0 && !flush; instr_data/instr_pc = slot[rd] fields; on pop rd increments and slot cleared.
REQ-017 Memory latency >=1 cycle: response earliest the cycle after imem_req; with latency 1, DEPTH 2 and instr_ready held 1, one instruction per cycle in steady state.
REQ-018 Simultaneous accept, fill and pop in one cycle SHALL all take effect.
REQ-019 On flush: rd, fill, alloc reset to equal values; all filled bits cleared; no accept and no pop that cycle.
REQ-020 On flush: drop_cnt <= pending - (imem_rvalid ? 1 : 0); next state DRAIN if that value is non-zero, else RUN.
REQ-021 In DRAIN: each imem_rvalid discards its data and decrements drop_cnt; transition to RUN on the edge where drop_cnt goes 1->0; pc_ready held 0.
REQ-022 Flush asserted while in DRAIN SHALL leave drop_cnt and state unchanged.
REQ-023 imem_rvalid with pending==0 in RUN is a protocol error: data ignored, no state change; the bench flags it by assertion.

Reset
REQ-024 On rst: alloc/fill/rd = 0, all filled = 0, drop_cnt = 0, state = RUN.
REQ-025 During rst: pc_ready, imem_req, instr_valid = 0; imem_addr, instr_data, instr_pc = 0.
REQ-026 Reset mid-operation SHALL abandon in-flight fetches without draining; the memory model is reset in the same cycle.

Structure
REQ-027 Package ifetch_pkg SHALL hold the state typedef (RUN, DRAIN) and defaults for WIDTH, ILEN and DEPTH.
REQ-028 No sub-module: queue, pointers and FSM are inline; target 150-250 lines.

Verification
REQ-029 Streaming: PC 0,1,2,3; memory latency 1 returns 0xA0..0xA3; instr_ready=1 -> instr_pc 0..3 with data 0xA0..0xA3 on four consecutive cycles.
REQ-030 Backpressure: instr_ready=0 for 5 cycles after 2 accepts -> pc_ready=0 once count==2, instr_valid held with pc 0; release -> pc 0 then 1, no loss or duplication.
REQ-031 Flush in flight: latency 3, 2 requests outstanding, flush -> drop_cnt=2, DRAIN; both responses discarded, instr_valid stays 0; RUN resumes and next PC 0x40 fetches correctly.
REQ-032 Flush coincident with rvalid: pending=1 -> drop_cnt=0, stays RUN, response discarded; pc_ready=1 the next cycle.
REQ-033 Reset mid-stream: rst during DRAIN with drop_cnt=1 -> all outputs 0 next cycle, state RUN, first post-reset fetch at PC 0 returns correct data.
REQ-034 Wrap: 10 fetches with DEPTH=2 and random latency 1-4 -> in-order delivery, pointer wrap clean, count never exceeds 2.
